// File: rtl/lcd_buf_arb.sv
// Two-requester arbiter in front of a 32-byte text-LCD character buffer (write/cursor 1 cycle, clears 16/32 cycles).
// Arbitration is round-robin by default; define LCD_BUF_ARB_FIXED_PRIO_EN to make requester 0 always win contention.
module lcd_buf_arb #(
    parameter logic [7:0] CLR_CHAR = 8'h20
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         req0,
    input  logic [1:0]   cmd0,
    input  logic [7:0]   arg0,
    output logic         gnt0,
    input  logic         req1,
    input  logic [1:0]   cmd1,
    input  logic [7:0]   arg1,
    output logic         gnt1,
    output logic [4:0]   cur0,
    output logic [4:0]   cur1,
    output logic         busy,
    output logic [127:0] lcd_l1,
    output logic [127:0] lcd_l2
);

    localparam logic [1:0] OP_WRITE    = 2'b00;
    localparam logic [1:0] OP_CLR_ALL  = 2'b10;
    localparam logic [1:0] OP_CLR_LINE = 2'b11;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        EXEC  = 2'd1,
        CLEAR = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [1:0]        cmd_q, cmd_d;
    logic [7:0]        arg_q, arg_d;
    logic              id_q, id_d;
    logic [4:0]        cur0_q, cur0_d;
    logic [4:0]        cur1_q, cur1_d;
    logic [4:0]        clr_addr_q, clr_addr_d;
    logic [31:0][7:0]  buf_q, buf_d;
`ifndef LCD_BUF_ARB_FIXED_PRIO_EN
    logic              last_q, last_d;
`endif

    logic              win;
    logic [1:0]        win_cmd;
    logic [4:0]        win_cur;
    logic [4:0]        cur_sel;
    logic [4:0]        cur_new;
    logic              cur_upd;
    logic              clr_done;

    always_comb begin
        state_d    = state_q;
        cmd_d      = cmd_q;
        arg_d      = arg_q;
        id_d       = id_q;
        cur0_d     = cur0_q;
        cur1_d     = cur1_q;
        clr_addr_d = clr_addr_q;
        buf_d      = buf_q;
`ifndef LCD_BUF_ARB_FIXED_PRIO_EN
        last_d     = last_q;
`endif
        gnt0       = 1'b0;
        gnt1       = 1'b0;
        cur_upd    = 1'b0;
        cur_new    = 5'd0;
        clr_done   = 1'b0;

`ifdef LCD_BUF_ARB_FIXED_PRIO_EN
        win = ~req0;
`else
        win = (req0 && req1) ? ~last_q : req1;
`endif
        win_cmd = win ? cmd1 : cmd0;
        win_cur = win ? cur1_q : cur0_q;
        cur_sel = id_q ? cur1_q : cur0_q;

        case (state_q)
            IDLE: begin
                if (req0 || req1) begin
                    id_d       = win;
                    cmd_d      = win_cmd;
                    arg_d      = win ? arg1 : arg0;
                    state_d    = win_cmd[1] ? CLEAR : EXEC;
                    // clear-line base is fixed by the requester's cursor at acceptance
                    clr_addr_d = (win_cmd == OP_CLR_ALL) ? 5'd0 : {win_cur[4], 4'b0000};
                end
            end
            EXEC: begin
                cur_upd = 1'b1;
                if (cmd_q == OP_WRITE) begin
                    buf_d[cur_sel] = arg_q;
                    cur_new        = cur_sel + 5'd1;
                end else begin
                    cur_new = arg_q[4:0];
                end
                gnt0    = ~id_q;
                gnt1    = id_q;
                state_d = IDLE;
            end
            CLEAR: begin
                buf_d[clr_addr_q] = CLR_CHAR;
                clr_addr_d        = clr_addr_q + 5'd1;
                clr_done          = (cmd_q == OP_CLR_LINE) ? (clr_addr_q[3:0] == 4'hF)
                                                           : (clr_addr_q == 5'd31);
                if (clr_done) begin
                    cur_upd = 1'b1;
                    cur_new = {clr_addr_q[4] & cmd_q[0], 4'b0000};
                    gnt0    = ~id_q;
                    gnt1    = id_q;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (cur_upd) begin
            if (id_q) cur1_d = cur_new;
            else      cur0_d = cur_new;
        end
`ifndef LCD_BUF_ARB_FIXED_PRIO_EN
        if (gnt0 || gnt1) last_d = id_q;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cmd_q      <= OP_WRITE;
            arg_q      <= 8'd0;
            id_q       <= 1'b0;
            cur0_q     <= 5'd0;
            cur1_q     <= 5'd0;
            clr_addr_q <= 5'd0;
            buf_q      <= {32{CLR_CHAR}};
`ifndef LCD_BUF_ARB_FIXED_PRIO_EN
            last_q     <= 1'b1;
`endif
        end else begin
            state_q    <= state_d;
            cmd_q      <= cmd_d;
            arg_q      <= arg_d;
            id_q       <= id_d;
            cur0_q     <= cur0_d;
            cur1_q     <= cur1_d;
            clr_addr_q <= clr_addr_d;
            buf_q      <= buf_d;
`ifndef LCD_BUF_ARB_FIXED_PRIO_EN
            last_q     <= last_d;
`endif
        end
    end

    assign cur0 = cur0_q;
    assign cur1 = cur1_q;
    assign busy = (state_q != IDLE);

    // character 1 of each line sits in the top byte
    for (genvar i = 0; i < 16; i++) begin : g_pack
        assign lcd_l1[127-8*i -: 8] = buf_q[i];
        assign lcd_l2[127-8*i -: 8] = buf_q[16+i];
    end

endmodule
